// File: rtl/rv32i_types.sv
// RV32I opcode constants and the reorder-buffer entry layout shared by the ROB.
package rv32i_types;

  localparam logic [6:0] store_opcode = 7'b0100011;
  localparam logic [6:0] br_opcode    = 7'b1100011;
  localparam logic [6:0] op_opcode    = 7'b0110011;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic        mispredict;
    logic [6:0]  opcode;
    logic [4:0]  rd_s;
    logic [31:0] rd_v;
    logic [31:0] pc;
    logic [31:0] target;
  } rob_entry_t;

endpackage

// File: rtl/rob_commit.sv
// In-order reorder buffer: allocate at tail, complete from the CDB, retire one head entry per cycle.
// Optional RVFI trace outputs are built when ROB_RVFI_EN is defined.
module rob_commit
  import rv32i_types::*;
#(
  parameter int ROB_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_valid,
  input  logic [6:0]           alloc_opcode,
  input  logic [4:0]           alloc_rd_s,
  input  logic [31:0]          alloc_pc,
`ifdef ROB_RVFI_EN
  input  logic [31:0]          alloc_inst,
  input  logic [4:0]           alloc_rs1_s,
  input  logic [4:0]           alloc_rs2_s,
`endif
  output logic                 alloc_ready,
  output logic [ROB_DEPTH-1:0] alloc_rob,
  input  logic                 cdb_valid,
  input  logic [ROB_DEPTH-1:0] cdb_rob,
  input  logic [31:0]          cdb_rd_v,
  input  logic                 cdb_mispredict,
  input  logic [31:0]          cdb_target,
  input  logic [ROB_DEPTH-1:0] rd_rs1_rob,
  input  logic [ROB_DEPTH-1:0] rd_rs2_rob,
  output logic                 rd_rs1_ready,
  output logic                 rd_rs2_ready,
  output logic [31:0]          rd_rs1_v,
  output logic [31:0]          rd_rs2_v,
  output logic                 commit_regfile_we,
  output logic [4:0]           commit_rd_s,
  output logic [31:0]          commit_rd_v,
  output logic [ROB_DEPTH-1:0] commit_rob,
  output logic                 commit_store,
`ifdef ROB_RVFI_EN
  output logic                 rvfi_valid,
  output logic [63:0]          rvfi_order,
  output logic [31:0]          rvfi_inst,
  output logic [4:0]           rvfi_rs1_s,
  output logic [4:0]           rvfi_rs2_s,
`endif
  output logic                 move_flush,
  output logic [31:0]          flush_pc
);

  localparam int ENTRIES = 2 ** ROB_DEPTH;
  localparam logic [ROB_DEPTH:0] PTR_ONE = {{ROB_DEPTH{1'b0}}, 1'b1};

  rob_entry_t          r_rob [ENTRIES];
  logic [ROB_DEPTH:0]  r_head;
  logic [ROB_DEPTH:0]  r_tail;

  logic [ROB_DEPTH-1:0] w_head_idx;
  logic [ROB_DEPTH-1:0] w_tail_idx;
  rob_entry_t           w_head_e;
  logic                 w_full;
  logic                 w_fire;
  logic                 w_flush;
  logic                 w_alloc;
  logic                 w_unused_pc;

  assign w_head_idx = r_head[ROB_DEPTH-1:0];
  assign w_tail_idx = r_tail[ROB_DEPTH-1:0];
  assign w_head_e   = r_rob[w_head_idx];
  assign w_full     = (w_head_idx == w_tail_idx) && (r_head[ROB_DEPTH] != r_tail[ROB_DEPTH]);
  assign w_fire     = w_head_e.valid && w_head_e.done;
  assign w_flush    = w_fire && w_head_e.mispredict;
  // Full is judged on pre-commit state, so a retiring slot is not reusable until next cycle.
  assign w_alloc    = alloc_valid && !w_full;
  // The PC is kept per entry for debug/trace but nothing downstream consumes it yet.
  assign w_unused_pc = ^w_head_e.pc;

  assign alloc_ready = !w_full;
  assign alloc_rob   = w_tail_idx;

  // Retire and flush interface, decoded straight from the head entry.
  always_comb begin
    commit_regfile_we = 1'b0;
    commit_store      = 1'b0;
    commit_rd_s       = 5'd0;
    commit_rd_v       = 32'd0;
    commit_rob        = {ROB_DEPTH{1'b0}};
    move_flush        = 1'b0;
    flush_pc          = 32'd0;
    if (w_fire) begin
      commit_regfile_we = (w_head_e.opcode != store_opcode) && (w_head_e.opcode != br_opcode);
      commit_store      = (w_head_e.opcode == store_opcode);
      commit_rd_s       = w_head_e.rd_s;
      commit_rd_v       = w_head_e.rd_v;
      commit_rob        = w_head_idx;
      move_flush        = w_head_e.mispredict;
      flush_pc          = w_head_e.mispredict ? w_head_e.target : 32'd0;
    end else begin
      commit_regfile_we = 1'b0;
    end
  end

  // Operand lookup for issue; CDB bypass is handled by the issue stage itself.
  always_comb begin
    rd_rs1_ready = r_rob[rd_rs1_rob].valid && r_rob[rd_rs1_rob].done;
    rd_rs2_ready = r_rob[rd_rs2_rob].valid && r_rob[rd_rs2_rob].done;
    rd_rs1_v     = r_rob[rd_rs1_rob].rd_v;
    rd_rs2_v     = r_rob[rd_rs2_rob].rd_v;
  end

  // Entry storage and pointers; flush discards any same-cycle alloc or CDB write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) r_rob[i] <= '0;
      r_head <= '0;
      r_tail <= '0;
    end else if (w_flush) begin
      for (int i = 0; i < ENTRIES; i++) r_rob[i].valid <= 1'b0;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_alloc) begin
        r_rob[w_tail_idx] <= rob_entry_t'{valid: 1'b1, done: 1'b0, mispredict: 1'b0,
                                          opcode: alloc_opcode, rd_s: alloc_rd_s,
                                          rd_v: 32'd0, pc: alloc_pc, target: 32'd0};
        r_tail <= r_tail + PTR_ONE;
      end
      if (cdb_valid && r_rob[cdb_rob].valid) begin
        r_rob[cdb_rob].done       <= 1'b1;
        r_rob[cdb_rob].rd_v       <= cdb_rd_v;
        r_rob[cdb_rob].mispredict <= cdb_mispredict;
        r_rob[cdb_rob].target     <= cdb_target;
      end
      // Placed last so a same-cycle CDB write to the head is overridden by the clear.
      if (w_fire) begin
        r_rob[w_head_idx] <= '0;
        r_head <= r_head + PTR_ONE;
      end
    end
  end

`ifdef ROB_RVFI_EN
  logic [31:0] r_inst [ENTRIES];
  logic [4:0]  r_rs1_s [ENTRIES];
  logic [4:0]  r_rs2_s [ENTRIES];
  logic [63:0] r_order;

  assign rvfi_valid = w_fire;
  assign rvfi_order = w_fire ? r_order : 64'd0;
  assign rvfi_inst  = w_fire ? r_inst[w_head_idx] : 32'd0;
  assign rvfi_rs1_s = w_fire ? r_rs1_s[w_head_idx] : 5'd0;
  assign rvfi_rs2_s = w_fire ? r_rs2_s[w_head_idx] : 5'd0;

  // Trace side storage and the free-running retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_inst[i]  <= 32'd0;
        r_rs1_s[i] <= 5'd0;
        r_rs2_s[i] <= 5'd0;
      end
      r_order <= 64'd0;
    end else begin
      if (w_alloc && !w_flush) begin
        r_inst[w_tail_idx]  <= alloc_inst;
        r_rs1_s[w_tail_idx] <= alloc_rs1_s;
        r_rs2_s[w_tail_idx] <= alloc_rs2_s;
      end
      if (w_fire) r_order <= r_order + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rob_commit.sv
// Directed-vector bench for rob_commit (default build, ROB_DEPTH=4).
module tb_rob_commit;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [6:0]  alloc_opcode;
  logic [4:0]  alloc_rd_s;
  logic [31:0] alloc_pc;
  logic        alloc_ready;
  logic [3:0]  alloc_rob;
  logic        cdb_valid;
  logic [3:0]  cdb_rob;
  logic [31:0] cdb_rd_v;
  logic        cdb_mispredict;
  logic [31:0] cdb_target;
  logic [3:0]  rd_rs1_rob, rd_rs2_rob;
  logic        rd_rs1_ready, rd_rs2_ready;
  logic [31:0] rd_rs1_v, rd_rs2_v;
  logic        commit_regfile_we;
  logic [4:0]  commit_rd_s;
  logic [31:0] commit_rd_v;
  logic [3:0]  commit_rob;
  logic        commit_store;
  logic        move_flush;
  logic [31:0] flush_pc;

  int n_vec  = 0;
  int n_miss = 0;

  rob_commit #(.ROB_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_opcode(alloc_opcode), .alloc_rd_s(alloc_rd_s),
    .alloc_pc(alloc_pc), .alloc_ready(alloc_ready), .alloc_rob(alloc_rob),
    .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_rd_v(cdb_rd_v),
    .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
    .rd_rs1_rob(rd_rs1_rob), .rd_rs2_rob(rd_rs2_rob),
    .rd_rs1_ready(rd_rs1_ready), .rd_rs2_ready(rd_rs2_ready),
    .rd_rs1_v(rd_rs1_v), .rd_rs2_v(rd_rs2_v),
    .commit_regfile_we(commit_regfile_we), .commit_rd_s(commit_rd_s),
    .commit_rd_v(commit_rd_v), .commit_rob(commit_rob), .commit_store(commit_store),
    .move_flush(move_flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs settle and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alloc(input logic v, input logic [6:0] op, input logic [4:0] rd);
    alloc_valid  = v;
    alloc_opcode = op;
    alloc_rd_s   = rd;
    alloc_pc     = {27'd0, rd} << 2;
  endtask

  task automatic set_cdb(input logic v, input logic [3:0] idx, input logic [31:0] val,
                         input logic mp, input logic [31:0] tgt);
    cdb_valid      = v;
    cdb_rob        = idx;
    cdb_rd_v       = val;
    cdb_mispredict = mp;
    cdb_target     = tgt;
  endtask

  initial begin
    rst = 1'b1;
    set_alloc(1'b0, 7'd0, 5'd0);
    set_cdb(1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
    rd_rs1_rob = 4'd0;
    rd_rs2_rob = 4'd0;
    tick(); tick();
    rst = 1'b0;

    check_vec("rst_ready", {63'd0, alloc_ready}, 64'd1);
    check_vec("rst_rob", {60'd0, alloc_rob}, 64'd0);
    check_vec("rst_we", {63'd0, commit_regfile_we}, 64'd0);
    check_vec("rst_flush", {63'd0, move_flush}, 64'd0);

    // Fill all 16 entries from empty.
    for (int k = 0; k < 16; k++) begin
      set_alloc(1'b1, op_opcode, 5'(k + 1));
      check_vec("fill_rob", {60'd0, alloc_rob}, 64'(k));
      tick();
    end
    check_vec("full_ready", {63'd0, alloc_ready}, 64'd0);
    check_vec("full_rob", {60'd0, alloc_rob}, 64'd0);
    set_alloc(1'b1, op_opcode, 5'd20);
    set_cdb(1'b1, 4'd0, 32'h11, 1'b0, 32'd0);
    tick();
    set_cdb(1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
    check_vec("full_fire_we", {63'd0, commit_regfile_we}, 64'd1);
    check_vec("full_fire_v", {32'd0, commit_rd_v}, 64'h11);
    check_vec("full_fire_ready", {63'd0, alloc_ready}, 64'd0);
    tick();
    check_vec("after_commit_ready", {63'd0, alloc_ready}, 64'd1);
    check_vec("after_commit_rob", {60'd0, alloc_rob}, 64'd0);
    tick();
    set_alloc(1'b0, 7'd0, 5'd0);
    check_vec("wrap_alloc_full", {63'd0, alloc_ready}, 64'd0);
    check_vec("wrap_alloc_rob", {60'd0, alloc_rob}, 64'd1);

    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Three ops, out-of-order completion, in-order retire.
    for (int k = 0; k < 3; k++) begin
      set_alloc(1'b1, op_opcode, 5'(k + 1));
      check_vec("s1_alloc_rob", {60'd0, alloc_rob}, 64'(k));
      tick();
    end
    set_alloc(1'b0, 7'd0, 5'd0);
    set_cdb(1'b1, 4'd2, 32'hA0, 1'b0, 32'd0);
    tick();
    check_vec("s1_rob0_wait", {63'd0, commit_regfile_we}, 64'd0);
    set_cdb(1'b1, 4'd0, 32'hB0, 1'b0, 32'd0);
    tick();
    set_cdb(1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
    check_vec("s1_c0_we", {63'd0, commit_regfile_we}, 64'd1);
    check_vec("s1_c0_rd", {59'd0, commit_rd_s}, 64'd1);
    check_vec("s1_c0_v", {32'd0, commit_rd_v}, 64'hB0);
    check_vec("s1_c0_rob", {60'd0, commit_rob}, 64'd0);
    tick();
    rd_rs1_rob = 4'd2;
    #1;
    check_vec("s1_rob2_blocked", {63'd0, commit_regfile_we}, 64'd0);
    check_vec("s1_lk2_ready", {63'd0, rd_rs1_ready}, 64'd1);
    check_vec("s1_lk2_v", {32'd0, rd_rs1_v}, 64'hA0);
    set_cdb(1'b1, 4'd1, 32'hC0, 1'b0, 32'd0);
    tick();
    set_cdb(1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
    check_vec("s1_c1_rd", {59'd0, commit_rd_s}, 64'd2);
    check_vec("s1_c1_v", {32'd0, commit_rd_v}, 64'hC0);
    tick();
    check_vec("s1_c2_rd", {59'd0, commit_rd_s}, 64'd3);
    check_vec("s1_c2_rob", {60'd0, commit_rob}, 64'd2);
    tick();
    check_vec("s1_empty_we", {63'd0, commit_regfile_we}, 64'd0);

    // Mispredicted branch at rob3 with younger entries behind it.
    set_alloc(1'b1, br_opcode, 5'd0);
    check_vec("fl_br_rob", {60'd0, alloc_rob}, 64'd3);
    tick();
    set_alloc(1'b1, op_opcode, 5'd5);
    tick();
    set_alloc(1'b1, op_opcode, 5'd6);
    tick();
    set_alloc(1'b0, 7'd0, 5'd0);
    set_cdb(1'b1, 4'd4, 32'h55, 1'b0, 32'd0);
    tick();
    set_cdb(1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
    rd_rs1_rob = 4'd4;
    rd_rs2_rob = 4'd5;
    #1;
    check_vec("lk4_ready", {63'd0, rd_rs1_ready}, 64'd1);
    check_vec("lk4_v", {32'd0, rd_rs1_v}, 64'h55);
    check_vec("lk5_notdone", {63'd0, rd_rs2_ready}, 64'd0);
    check_vec("br_not_done", {63'd0, commit_regfile_we | move_flush}, 64'd0);
    set_cdb(1'b1, 4'd3, 32'd0, 1'b1, 32'h1000);
    tick();
    set_cdb(1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
    set_alloc(1'b1, op_opcode, 5'd7);
    check_vec("fl_flush", {63'd0, move_flush}, 64'd1);
    check_vec("fl_pc", {32'd0, flush_pc}, 64'h1000);
    check_vec("fl_we", {63'd0, commit_regfile_we}, 64'd0);
    check_vec("fl_rob", {60'd0, commit_rob}, 64'd3);
    tick();
    set_alloc(1'b0, 7'd0, 5'd0);
    check_vec("fl_after_rob", {60'd0, alloc_rob}, 64'd0);
    check_vec("fl_after_flush", {63'd0, move_flush}, 64'd0);
    check_vec("fl_after_pc", {32'd0, flush_pc}, 64'd0);
    check_vec("fl_lk4_cleared", {63'd0, rd_rs1_ready}, 64'd0);

    // Store then non-mispredicted branch retiring.
    set_alloc(1'b1, store_opcode, 5'd9);
    tick();
    set_alloc(1'b1, br_opcode, 5'd0);
    tick();
    set_alloc(1'b0, 7'd0, 5'd0);
    set_cdb(1'b1, 4'd0, 32'd0, 1'b0, 32'd0);
    tick();
    set_cdb(1'b1, 4'd1, 32'd0, 1'b0, 32'h2000);
    check_vec("st_store", {63'd0, commit_store}, 64'd1);
    check_vec("st_we", {63'd0, commit_regfile_we}, 64'd0);
    check_vec("st_rob", {60'd0, commit_rob}, 64'd0);
    tick();
    set_cdb(1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
    check_vec("br_store", {63'd0, commit_store}, 64'd0);
    check_vec("br_we", {63'd0, commit_regfile_we}, 64'd0);
    check_vec("br_flush", {63'd0, move_flush}, 64'd0);
    check_vec("br_rob", {60'd0, commit_rob}, 64'd1);
    tick();

    // Reset with 5 pending entries, head one completed.
    for (int k = 0; k < 5; k++) begin
      set_alloc(1'b1, op_opcode, 5'(k + 10));
      tick();
    end
    set_alloc(1'b0, 7'd0, 5'd0);
    set_cdb(1'b1, 4'd2, 32'h77, 1'b0, 32'd0);
    tick();
    set_cdb(1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
    rd_rs1_rob = 4'd3;
    rd_rs2_rob = 4'd2;
    check_vec("pre_rst_alloc_rob", {60'd0, alloc_rob}, 64'd7);
    rst = 1'b1;
    set_cdb(1'b1, 4'd3, 32'h99, 1'b0, 32'd0);
    tick();
    rst = 1'b0;
    set_cdb(1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
    check_vec("r2_ready", {63'd0, alloc_ready}, 64'd1);
    check_vec("r2_rob", {60'd0, alloc_rob}, 64'd0);
    check_vec("r2_we", {63'd0, commit_regfile_we}, 64'd0);
    check_vec("r2_rd_v", {32'd0, commit_rd_v}, 64'd0);
    check_vec("r2_lk1_ready", {63'd0, rd_rs1_ready}, 64'd0);
    check_vec("r2_lk1_v", {32'd0, rd_rs1_v}, 64'd0);
    check_vec("r2_lk2_v", {32'd0, rd_rs2_v}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
